// File: rtl/mem_arbiter.sv
// Two-requester (data/instruction) line-memory arbiter with round-robin tie
// breaking, single-cycle command strobes, registered completions and a WAIT timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_addr,
    input  logic [127:0] d_wdata,
    output logic         d_ready,
    output logic [127:0] d_rdata,
    input  logic         i_read,
    input  logic [31:0]  i_addr,
    output logic         i_ready,
    output logic [127:0] i_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_data_to_mem,
    input  logic         mem_ready,
    input  logic [127:0] mem_data_from_mem,
    output logic         busy,
    output logic         timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         last_d_q, last_d_d;   // 1 = data side won the previous grant
    logic         gnt_d_q, gnt_d_d;     // 1 = current transaction belongs to data side
    logic         op_wr_q, op_wr_d;
    logic         d_ready_q, d_ready_d;
    logic         i_ready_q, i_ready_d;
    logic [127:0] d_rdata_q, d_rdata_d;
    logic [127:0] i_rdata_q, i_rdata_d;
    logic         mem_read_q, mem_read_d;
    logic         mem_write_q, mem_write_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;
    logic         busy_q, busy_d;
    logic         timeout_err_q, timeout_err_d;

    logic d_req, pick_d;

    assign d_req  = d_read | d_write;
    assign pick_d = d_req & (~i_read | ~last_d_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d_d      = last_d_q;
        gnt_d_d       = gnt_d_q;
        op_wr_d       = op_wr_q;
        d_ready_d     = 1'b0;
        i_ready_d     = 1'b0;
        d_rdata_d     = d_rdata_q;
        i_rdata_d     = i_rdata_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (d_req | i_read) begin
                    gnt_d_d  = pick_d;
                    last_d_d = pick_d;
                    if (pick_d) begin
                        // A simultaneous read+write from the data side is a read.
                        op_wr_d    = d_write & ~d_read;
                        mem_addr_d = d_addr & 32'hFFFF_FFF0;
                        if (d_write & ~d_read) mem_wdata_d = d_wdata;
                    end else begin
                        op_wr_d    = 1'b0;
                        mem_addr_d = i_addr;
                    end
                    mem_read_d  = ~op_wr_d;
                    mem_write_d = op_wr_d;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    if (gnt_d_q) begin
                        d_ready_d = 1'b1;
                        if (!op_wr_q) d_rdata_d = mem_data_from_mem;
                    end else begin
                        i_ready_d = 1'b1;
                        i_rdata_d = mem_data_from_mem;
                    end
                    state_d = DONE;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
                    timeout_err_d = 1'b1;
                    if (gnt_d_q) begin
                        d_ready_d = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        i_ready_d = 1'b1;
                        i_rdata_d = '0;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_d_q      <= 1'b0;
            gnt_d_q       <= 1'b0;
            op_wr_q       <= 1'b0;
            d_ready_q     <= 1'b0;
            i_ready_q     <= 1'b0;
            d_rdata_q     <= '0;
            i_rdata_q     <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_d_q      <= last_d_d;
            gnt_d_q       <= gnt_d_d;
            op_wr_q       <= op_wr_d;
            d_ready_q     <= d_ready_d;
            i_ready_q     <= i_ready_d;
            d_rdata_q     <= d_rdata_d;
            i_rdata_q     <= i_rdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign d_ready         = d_ready_q;
    assign d_rdata         = d_rdata_q;
    assign i_ready         = i_ready_q;
    assign i_rdata         = i_rdata_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_addr        = mem_addr_q;
    assign mem_data_to_mem = mem_wdata_q;
    assign busy            = busy_q;
    assign timeout_err     = timeout_err_q;

endmodule
